// File: rtl/mult_share_pkg.sv
// Shared constants, ID-width helper and datapath types for the shared multiplier.
package mult_share_pkg;

  localparam int WIDTH_DEF = 2;
  localparam int NREQ_DEF  = 4;
  localparam int CNTW_DEF  = 16;

  // Requester ID width; a single requester still needs one bit of ID.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDW_DEF = idw_f(NREQ_DEF);

  typedef logic [WIDTH_DEF-1:0]   operand_t;
  typedef logic [2*WIDTH_DEF-1:0] product_t;
  typedef logic [IDW_DEF-1:0]     req_id_t;

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin arbiter: rotate the request vector so rr_ptr lands on
// bit 0, pick the lowest set bit, then map that offset back to a real requester index.
module mult_rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic              found;
  logic [IDW:0]      sum;

  // Rotate, priority-encode, and un-rotate with a wrap at NREQ rather than 2^IDW.
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr;
    rot   = dbl[NREQ-1:0];
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = i[IDW-1:0];
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NREQ_W) begin
      sum = sum - NREQ_W;
    end
    grant_idx = sum[IDW-1:0];
    any_valid = |req_valid;
    grant_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = any_valid && (grant_idx == i[IDW-1:0]);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// One unsigned multiplier shared by NREQ requesters under round-robin arbitration,
// with a single registered response stage carrying the product and the winner's ID.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = idw_f(NREQ),
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_out,
  output logic [IDW-1:0]        rsp_id,
  output logic [CNTW-1:0]       ops_count
);

  logic [NREQ-1:0]    grant_oh;
  logic [IDW-1:0]     grant_idx;
  logic               any_valid;
  logic               slot_free;
  logic               accept;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [2*WIDTH-1:0] product;

  logic               rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_out_q,   rsp_out_d;
  logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CNTW-1:0]    ops_count_q, ops_count_d;

  mult_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Handshake: accept whenever the response slot is empty or being drained this cycle.
  always_comb begin
    slot_free = !rsp_valid_q || rsp_ready;
    accept    = slot_free && any_valid;
    req_ready = (accept && rst_n) ? grant_oh : '0;
  end

  // Operand mux driven by the one-hot grant, then the shared multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
    product = {{WIDTH{1'b0}}, a_sel} * {{WIDTH{1'b0}}, b_sel};
  end

  // Next-state: load on accept, drop valid on a bare consume, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    ops_count_d = ops_count_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_out_d   = product;
      rsp_id_d    = grant_idx;
      rr_ptr_d    = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      ops_count_d = ops_count_q + CNTW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending result and restarts priority at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      ops_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_id    = rsp_id_q;
  assign ops_count = ops_count_q;

endmodule
